fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined LoongArch core. It replaces the single-cycle PC register with several pieces:
- a PC generator;
- a synchronous inst SRAM request port with 1-cycle read latency;
- an instruction queue that decouples fetch from decode through a valid/allowin handshake.

Branch/jump redirects from decode flush the queue and any in-flight read.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_queue.sv | 74 +++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : constants shared by the fetch and decode stages            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

   localparam int          PC_W_DEFAULT     = 32;
   localparam int          INST_W_DEFAULT   = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam int          FS_TO_DS_BUS_W   = PC_W_DEFAULT + INST_W_DEFAULT;
   localparam int          BR_BUS_W         = 1 + PC_W_DEFAULT;

   typedef struct packed {
      logic [PC_W_DEFAULT-1:0]   pc;
      logic [INST_W_DEFAULT-1:0] inst;
   } fs_to_ds_bus_t;

   // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
   function automatic int iq_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : inst SRAM, redirect and fetch-to-decode signals      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_unit_if
   import cpu_pkg::*;
#(
   parameter int PC_W   = PC_W_DEFAULT,
   parameter int INST_W = INST_W_DEFAULT
);
   logic              inst_sram_en;
   logic              inst_sram_we;
   logic [PC_W-1:0]   inst_sram_addr;
   logic [INST_W-1:0] inst_sram_wdata;
   logic [INST_W-1:0] inst_sram_rdata;
   logic              br_taken;
   logic [PC_W-1:0]   br_target;
   logic              ds_allowin;
   logic              fs_to_ds_valid;
   logic [PC_W-1:0]   fs_to_ds_pc;
   logic [INST_W-1:0] fs_to_ds_inst;

   modport master (
      output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
      input  inst_sram_rdata,
      input  br_taken, br_target, ds_allowin,
      output fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst
   );

   modport slave (
      input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
      output inst_sram_rdata,
      output br_taken, br_target, ds_allowin,
      input  fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : synchronous FIFO with push, pop, flush and occupancy   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_queue #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   input  wire logic                   flush,
   input  wire logic                   push,
   input  wire logic [WIDTH-1:0]       push_data,
   input  wire logic                   pop,
   output logic      [WIDTH-1:0]       head_data,
   output logic      [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap for free because DEPTH is a power of two.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = mem_q[head_q];
   assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC generator, 1-cycle inst SRAM port, instruction queue |
// | Option macro FETCH_BYPASS_EN : empty-queue return forwarded same cycle |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter int              INST_W   = INST_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
   parameter int              IQ_DEPTH = 4
) (
   input  wire logic   clk,
   input  wire logic   reset,
   fetch_unit_if.master bus
);
   localparam int CNT_W = iq_cnt_w(IQ_DEPTH);
   localparam int QW    = PC_W + INST_W;

   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic             inflight_q, inflight_d;
   logic [CNT_W-1:0] iq_count;
   logic [QW-1:0]    iq_head;
   logic [PC_W-1:0]  req_addr;
   logic             issue;
   logic             ret_valid;
   logic             byp_sel;
   logic             iq_push;
   logic             iq_pop;
   logic             unused_br_lsb;

   assign req_addr = {fetch_pc_q[PC_W-1:2], 2'b00};

   // Counting the outstanding read guarantees its return always finds a free slot.
   assign issue = !reset && !bus.br_taken &&
                  ((iq_count + CNT_W'(inflight_q)) < CNT_W'(IQ_DEPTH));

   assign ret_valid = inflight_q && !reset && !bus.br_taken;

`ifdef FETCH_BYPASS_EN
   assign byp_sel = ret_valid && (iq_count == '0);
`else
   assign byp_sel = 1'b0;
`endif

   assign iq_push = ret_valid && !(byp_sel && bus.ds_allowin);
   assign iq_pop  = (iq_count != '0) && bus.ds_allowin && !bus.br_taken && !reset;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      if (bus.br_taken) begin
         fetch_pc_d = {bus.br_target[PC_W-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + PC_W'(4);
         inflight_pc_d = req_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_queue #(
      .WIDTH (QW),
      .DEPTH (IQ_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.br_taken),
      .push      (iq_push),
      .push_data ({inflight_pc_q, bus.inst_sram_rdata}),
      .pop       (iq_pop),
      .head_data (iq_head),
      .count     (iq_count)
   );

   assign bus.inst_sram_en    = issue;
   assign bus.inst_sram_we    = 1'b0;
   assign bus.inst_sram_addr  = req_addr;
   assign bus.inst_sram_wdata = '0;

   // Valid is masked during reset so a full queue never leaks across it.
   assign bus.fs_to_ds_valid = !reset && ((iq_count != '0) || byp_sel);
   assign bus.fs_to_ds_pc    = byp_sel ? inflight_pc_q        : iq_head[QW-1:INST_W];
   assign bus.fs_to_ds_inst  = byp_sel ? bus.inst_sram_rdata  : iq_head[INST_W-1:0];

   assign unused_br_lsb = ^bus.br_target[1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_fetch_unit : randomized and directed bench with a queue-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
   localparam int          PC_W   = 32;
   localparam int          INST_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h1c00_0000;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_unit_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

   fetch_unit #(
      .PC_W     (PC_W),
      .INST_W   (INST_W),
      .RESET_PC (RST_PC),
      .IQ_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: architectural fetch PC, at most one outstanding read, FIFO of fetched PCs.
   logic [31:0] m_pc;
   logic [31:0] m_inf_pc;
   bit          m_inf;
   logic [31:0] m_q[$];

   bit          in_rst = 1'b1, in_br, in_allow;
   logic [31:0] in_tgt;
   bit          exp_en, exp_valid, exp_byp;
   logic [31:0] exp_addr, exp_pc, exp_inst;
   bit          pend;
   logic [31:0] pend_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
   endfunction

   function automatic void model_expect();
      bit ret;
      exp_en   = !in_rst && !in_br && ((m_q.size() + int'(m_inf)) < DEPTH);
      exp_addr = m_pc & 32'hffff_fffc;
      ret      = m_inf && !in_rst && !in_br;
`ifdef FETCH_BYPASS_EN
      exp_byp  = ret && (m_q.size() == 0);
`else
      exp_byp  = 1'b0;
`endif
      exp_valid = !in_rst && ((m_q.size() != 0) || exp_byp);
      exp_pc    = (m_q.size() != 0) ? m_q[0] : m_inf_pc;
      exp_inst  = mem_word(exp_pc);
   endfunction

   function automatic void model_commit();
      bit ret;
      ret       = m_inf && !in_rst && !in_br;
      pend      = exp_en;
      pend_addr = exp_addr;
      if (in_rst) begin
         m_pc  = RST_PC;
         m_inf = 1'b0;
         m_q.delete();
      end else if (in_br) begin
         m_q.delete();
         m_inf = 1'b0;
         m_pc  = in_tgt & 32'hffff_fffc;
      end else begin
         if (exp_valid && in_allow && !exp_byp) void'(m_q.pop_front());
         if (ret && !(exp_byp && in_allow)) m_q.push_back(m_inf_pc);
         m_inf = exp_en;
         if (exp_en) begin
            m_inf_pc = exp_addr;
            m_pc     = m_pc + 32'd4;
         end
      end
   endfunction

   // One clock cycle: retire the model's previous cycle, apply inputs, compute expectations.
   task automatic drive(input bit rst, input bit br, input logic [31:0] tgt, input bit allow);
      @(posedge clk);
      model_commit();
      #1;
      in_rst = rst; in_br = br; in_tgt = tgt; in_allow = allow;
      reset              = rst;
      bus.br_taken       = br;
      bus.br_target      = tgt;
      bus.ds_allowin     = allow;
      bus.inst_sram_rdata = pend ? mem_word(pend_addr) : $urandom();
      @(negedge clk);
      model_expect();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, '0, 1'b1);
         n_tests++;
         if (bus.inst_sram_en !== 1'b0 || bus.fs_to_ds_valid !== 1'b0 ||
             bus.inst_sram_we !== 1'b0 || bus.inst_sram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset cyc=%0d en=%b vld=%b we=%b wdata=%h required all zero",
                     i, bus.inst_sram_en, bus.fs_to_ds_valid, bus.inst_sram_we, bus.inst_sram_wdata);
         end
      end
   endtask

   task automatic test_stream();
      logic [31:0] want_pc;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         n_tests++;
         if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC + 32'(4 * k)) begin
            n_fail++;
            $display("FAIL stream_issue k=%0d en=%b addr=%h required en=1 addr=%h",
                     k, bus.inst_sram_en, bus.inst_sram_addr, RST_PC + 32'(4 * k));
         end
         want_pc = RST_PC + 32'(4 * (k - LAT));
         n_tests++;
         if (bus.fs_to_ds_valid !== (k >= LAT) ||
             ((k >= LAT) && (bus.fs_to_ds_pc !== want_pc || bus.fs_to_ds_inst !== mem_word(want_pc)))) begin
            n_fail++;
            $display("FAIL stream_pop k=%0d vld=%b pc=%h inst=%h required vld=%b pc=%h inst=%h",
                     k, bus.fs_to_ds_valid, bus.fs_to_ds_pc, bus.fs_to_ds_inst,
                     (k >= LAT), want_pc, mem_word(want_pc));
         end
      end
   endtask

   task automatic test_stall();
      int issued = 0;
      drive(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, '0, 1'b0);
         if (bus.inst_sram_en === 1'b1) issued++;
      end
      n_tests++;
      if (issued != DEPTH || bus.inst_sram_en !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_issue count=%0d last_en=%b required count=%0d last_en=0",
                  issued, bus.inst_sram_en, DEPTH);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         n_tests++;
         if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_to_ds_pc !== RST_PC + 32'(4 * i) ||
             bus.fs_to_ds_inst !== mem_word(RST_PC + 32'(4 * i))) begin
            n_fail++;
            $display("FAIL stall_drain i=%0d vld=%b pc=%h inst=%h required vld=1 pc=%h",
                     i, bus.fs_to_ds_valid, bus.fs_to_ds_pc, bus.fs_to_ds_inst, RST_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect();
      logic [31:0] nxt = 32'h1c00_0100;
      int          seen = 0;
      drive(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b1, 32'h1c00_0100, 1'b1);
      n_tests++;
      if (bus.inst_sram_en !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_no_issue en=%b required 0", bus.inst_sram_en);
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0100) begin
         n_fail++;
         $display("FAIL redirect_next vld=%b en=%b addr=%h required vld=0 en=1 addr=1c000100",
                  bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr);
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         if (bus.fs_to_ds_valid === 1'b1) begin
            n_tests++;
            if (bus.fs_to_ds_pc !== nxt || bus.fs_to_ds_inst !== mem_word(nxt)) begin
               n_fail++;
               $display("FAIL redirect_seq pc=%h inst=%h required pc=%h inst=%h",
                        bus.fs_to_ds_pc, bus.fs_to_ds_inst, nxt, mem_word(nxt));
            end
            nxt += 32'd4;
            seen++;
         end
      end
      n_tests++;
      if (seen < 4) begin
         n_fail++;
         $display("FAIL redirect_progress delivered=%0d required >=4", seen);
      end
   endtask

   task automatic test_misaligned();
      drive(1'b0, 1'b1, 32'h1c00_0203, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0200) begin
         n_fail++;
         $display("FAIL misaligned_addr en=%b addr=%h required en=1 addr=1c000200",
                  bus.inst_sram_en, bus.inst_sram_addr);
      end
      for (int i = 1; i <= LAT; i++) drive(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_to_ds_pc !== 32'h1c00_0200) begin
         n_fail++;
         $display("FAIL misaligned_pop vld=%b pc=%h required vld=1 pc=1c000200",
                  bus.fs_to_ds_valid, bus.fs_to_ds_pc);
      end
   endtask

   task automatic test_redirect_push();
      logic [31:0] nxt = 32'h1c00_0400;
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b1, 32'h1c00_0400, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (bus.fs_to_ds_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_push_empty vld=%b pc=%h required vld=0", bus.fs_to_ds_valid, bus.fs_to_ds_pc);
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         if (bus.fs_to_ds_valid === 1'b1) begin
            n_tests++;
            if (bus.fs_to_ds_pc !== nxt) begin
               n_fail++;
               $display("FAIL redirect_push_seq pc=%h required %h", bus.fs_to_ds_pc, nxt);
            end
            nxt += 32'd4;
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] w_addr [4];
      w_addr = '{32'hffff_fff8, 32'hffff_fffc, 32'h0000_0000, 32'h0000_0004};
      drive(1'b0, 1'b1, 32'hffff_fff9, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         n_tests++;
         if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== w_addr[i]) begin
            n_fail++;
            $display("FAIL wrap i=%0d en=%b addr=%h required en=1 addr=%h",
                     i, bus.inst_sram_en, bus.inst_sram_addr, w_addr[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, '0, 1'b0);
         n_tests++;
         if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid cyc=%0d vld=%b en=%b required 0 0", i, bus.fs_to_ds_valid, bus.inst_sram_en);
         end
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC || bus.fs_to_ds_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_restart en=%b addr=%h vld=%b required en=1 addr=%h vld=0",
                  bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_valid, RST_PC);
      end
   endtask

   task automatic test_random();
      bit          rst, br, allow;
      logic [31:0] tgt;
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         br    = ($urandom_range(0, 99) < 6);
         tgt   = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 | 32'($urandom_range(0, 15)))
                                             : (RST_PC + 32'($urandom_range(0, 4095)));
         allow = ((i % 64) < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         drive(rst, br, tgt, allow);
         n_tests++;
         if (bus.inst_sram_en !== exp_en || bus.fs_to_ds_valid !== exp_valid ||
             (exp_en && bus.inst_sram_addr !== exp_addr) ||
             (exp_valid && (bus.fs_to_ds_pc !== exp_pc || bus.fs_to_ds_inst !== exp_inst))) begin
            n_fail++;
            $display("FAIL random cyc=%0d en=%b addr=%h vld=%b pc=%h inst=%h required en=%b addr=%h vld=%b pc=%h inst=%h",
                     i, bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_valid, bus.fs_to_ds_pc,
                     bus.fs_to_ds_inst, exp_en, exp_addr, exp_valid, exp_pc, exp_inst);
         end
      end
   endtask

   initial begin
      reset               = 1'b1;
      bus.br_taken        = 1'b0;
      bus.br_target       = '0;
      bus.ds_allowin      = 1'b0;
      bus.inst_sram_rdata = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misaligned();
      test_redirect_push();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
